// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding AXI4-Lite master bridging load/store requests
module axi4_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [3:0]            byte_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  write_done,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            read_data     <= '0;
            read_valid    <= 1'b0;
            write_done    <= 1'b0;
            resp_err      <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            read_valid <= 1'b0;
            write_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A store takes priority; a simultaneous load is simply not accepted.
                    if (mem_write) begin
                        M_AXI_AWADDR  <= addr;
                        M_AXI_WDATA   <= write_data;
                        M_AXI_WSTRB   <= byte_en;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        req_ready     <= 1'b0;
                        state         <= WR_REQ;
                    end else if (mem_read) begin
                        M_AXI_ARADDR  <= addr;
                        M_AXI_ARVALID <= 1'b1;
                        req_ready     <= 1'b0;
                        state         <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
                    // Each channel is done once its VALID has dropped or handshakes now.
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        resp_err     <= |M_AXI_BRESP;
                        write_done   <= 1'b1;
                        req_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        read_data    <= M_AXI_RDATA;
                        resp_err     <= |M_AXI_RRESP;
                        read_valid   <= 1'b1;
                        req_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - scoreboard bench for axi4_lite_master with a reactive slave
module tb_axi4_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [3:0]  byte_en = '0;
    logic [31:0] addr = '0, write_data = '0;
    logic        req_ready, read_valid, write_done, resp_err;
    logic [31:0] read_data;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .byte_en(byte_en), .addr(addr), .write_data(write_data),
        .req_ready(req_ready), .read_data(read_data), .read_valid(read_valid),
        .write_done(write_done), .resp_err(resp_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        bit          is_read;
        logic [31:0] rdata;
        bit          err;
        int          exp_cyc;
    } done_t;

    done_t       done_q[$];
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    logic [31:0] ar_q[$];

    // Slave behaviour knobs and per-channel wait counters
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    int aw_w = 0, w_w = 0, ar_w = 0, b_w = 0, r_w = 0;
    logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
    logic [31:0] cfg_rdata = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0;
            end else begin
                if (awvalid) begin awready = (aw_w >= aw_dly); aw_w++; end
                else begin awready = 0; aw_w = 0; end
                if (wvalid) begin wready = (w_w >= w_dly); w_w++; end
                else begin wready = 0; w_w = 0; end
                if (arvalid) begin arready = (ar_w >= ar_dly); ar_w++; end
                else begin arready = 0; ar_w = 0; end
                if (bready) begin bvalid = (b_w >= b_dly); bresp = cfg_bresp; b_w++; end
                else begin bvalid = 0; bresp = 0; b_w = 0; end
                if (rready) begin
                    rvalid = (r_w >= r_dly);
                    rdata  = rvalid ? cfg_rdata : 32'h0;
                    rresp  = cfg_rresp;
                    r_w++;
                end else begin
                    rvalid = 0; rdata = 0; rresp = 0; r_w = 0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT handshakes or completes
    logic [35:0] held_w = '0;
    bit w_stall = 0, aw_hs_prev = 0, wd_prev = 0, rv_prev = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (aw_hs_prev) check("awvalid_drop", awvalid, 0);
                if (w_stall && wvalid) check("w_stable", {wstrb, wdata}, held_w);
                if (wd_prev) check("write_done_width", write_done, 0);
                if (rv_prev) check("read_valid_width", read_valid, 0);
                if (bready && (awvalid || wvalid)) check("bready_early", 1, 0);
                if (rready && arvalid) check("rready_early", 1, 0);
                if (awvalid && awready) begin
                    if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
                    else check("aw_addr", awaddr, aw_q.pop_front());
                end
                if (wvalid && wready) begin
                    if (w_q.size() == 0) check("w_unexpected", 1, 0);
                    else check("w_data_strb", {wstrb, wdata}, w_q.pop_front());
                end
                if (arvalid && arready) begin
                    if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
                    else check("ar_addr", araddr, ar_q.pop_front());
                end
                if (write_done || read_valid) begin
                    if (done_q.size() == 0) check("done_unexpected", {write_done, read_valid}, 0);
                    else begin
                        done_t e;
                        e = done_q.pop_front();
                        check("done_kind", {write_done, read_valid}, e.is_read ? 2'b01 : 2'b10);
                        check("resp_err", resp_err, e.err);
                        if (e.is_read) check("read_data", read_data, e.rdata);
                        if (e.exp_cyc >= 0) check("done_latency", cyc, e.exp_cyc);
                    end
                end
                aw_hs_prev = awvalid && awready;
                w_stall    = wvalid && !wready;
                held_w     = {wstrb, wdata};
                wd_prev    = write_done;
                rv_prev    = read_valid;
            end
        end
    end

    // Present a request and hold it until an edge where req_ready was high
    task automatic req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc);
        mem_write = wr; mem_read = rd; addr = a; write_data = d; byte_en = s;
        acc = -1;
        for (int i = 0; i < 300 && acc < 0; i++) begin
            bit r;
            r = req_ready;
            @(posedge clk);
            #1;
            if (r) acc = cyc;
        end
        if (acc < 0) check("accept_timeout", 0, 1);
        mem_write = 0; mem_read = 0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            if (req_ready && done_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (i >= 300) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, acc2;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_valid_ready", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rst_pulses_err", {read_valid, write_done, resp_err}, 0);
        check("rst_addr_data", {awaddr, araddr, wdata}, 0);
        check("rst_read_data", read_data, 0);
        #2 rst = 0;
        @(posedge clk);
        #1;

        // zero-wait write
        aw_q.push_back(32'h100); w_q.push_back({4'hF, 32'hDEADBEEF});
        req(1, 0, 32'h100, 32'hDEADBEEF, 4'hF, acc);
        done_q.push_back('{0, 32'h0, 0, acc + 2});
        wait_idle();

        // WREADY three cycles after AWREADY, SLVERR response
        w_dly = 3; cfg_bresp = 2'b10;
        aw_q.push_back(32'h104); w_q.push_back({4'h3, 32'hCAFEF00D});
        req(1, 0, 32'h104, 32'hCAFEF00D, 4'h3, acc);
        done_q.push_back('{0, 32'h0, 1, acc + 5});
        wait_idle();

        // read with ARREADY after 2 cycles, SLVERR
        w_dly = 0; cfg_bresp = 0; ar_dly = 2; cfg_rdata = 32'h12345678; cfg_rresp = 2'b10;
        ar_q.push_back(32'h200);
        req(0, 1, 32'h200, 32'h0, 4'h0, acc);
        done_q.push_back('{1, 32'h12345678, 1, acc + 4});
        wait_idle();

        // simultaneous read+write: write first, held read follows at done edge
        ar_dly = 0; cfg_rresp = 0; cfg_rdata = 32'hA5A50F0F;
        aw_q.push_back(32'h300); w_q.push_back({4'hC, 32'h11112222});
        req(1, 1, 32'h300, 32'h11112222, 4'hC, acc);
        done_q.push_back('{0, 32'h0, 0, acc + 2});
        req(0, 1, 32'h304, 32'h0, 4'h0, acc2);
        ar_q.push_back(32'h304);
        check("read_after_write_accept", acc2, acc + 3);
        done_q.push_back('{1, 32'hA5A50F0F, 0, acc2 + 2});
        wait_idle();

        // back-to-back writes
        aw_q.push_back(32'h400); w_q.push_back({4'h1, 32'h00000001});
        req(1, 0, 32'h400, 32'h00000001, 4'h1, acc);
        done_q.push_back('{0, 32'h0, 0, acc + 2});
        aw_q.push_back(32'h408); w_q.push_back({4'h8, 32'h80000000});
        req(1, 0, 32'h408, 32'h80000000, 4'h8, acc2);
        check("b2b_accept", acc2, acc + 3);
        check("b2b_awvalid", awvalid, 1);
        done_q.push_back('{0, 32'h0, 0, acc2 + 2});
        wait_idle();
        check("read_data_held", read_data, 32'hA5A50F0F);

        // reset while ARVALID is stalled
        ar_dly = 100;
        req(0, 1, 32'h500, 32'h0, 4'h0, acc);
        repeat (2) @(posedge clk);
        #3;
        check("arvalid_before_rst", arvalid, 1);
        rst = 1;
        #1;
        check("rst_async_arvalid", arvalid, 0);
        check("rst_async_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        rst = 0;
        repeat (10) @(posedge clk);
        #1;
        check("no_read_after_rst", {arvalid, rready, req_ready}, 3'b001);
        check("scoreboard_drained", done_q.size() + aw_q.size() + w_q.size() + ar_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

Single-outstanding AXI4-Lite master that converts a simple processor-side load/store request into AXI4-Lite read or write transactions. It drives the initiator end of the unified AXI4-Lite bus toward the peripheral slaves, captures the response, and returns read data, completion and error status to the requester. One transaction is in flight at a time; the requester sees `req_ready` low while busy.

## Interface
- ADDR_WIDTH, 32, address width of request and AXI address channels
- DATA_WIDTH, 32, data width of request and AXI data channels
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_read  in  1  read request; sampled only when req_ready=1
- mem_write  in  1  write request; sampled only when req_ready=1; wins over mem_read
- byte_en  in  4  write byte strobes
- addr  in  ADDR_WIDTH  request address
- write_data  in  DATA_WIDTH  store data
- req_ready  out  1  high only in IDLE
- read_data  out  DATA_WIDTH  captured RDATA, held until next read completes
- read_valid  out  1  one-cycle pulse: read complete
- write_done  out  1  one-cycle pulse: write complete
- resp_err  out  1  valid with the done/valid pulse: 1 if xRESP != 2'b00
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master-side directions and widths (ADDR_WIDTH, DATA_WIDTH, 4-bit WSTRB, 2-bit xRESP)

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE: mem_write=1 → latch addr/write_data/byte_en, go WR_REQ; else mem_read=1 → latch addr, go RD_REQ; else stay.
- WR_REQ: AWVALID and WVALID both asserted on entry; each drops independently on its own handshake (VALID&READY); leave to WR_RESP once both handshakes done (same or different cycles, either order).
- WR_RESP: BREADY=1; on BVALID: latch BRESP into resp_err, pulse write_done next cycle, go IDLE.
- RD_REQ: ARVALID=1 until ARREADY; then RD_RESP.
- RD_RESP: RREADY=1; on RVALID: latch RDATA into read_data, RRESP into resp_err, pulse read_valid next cycle, go IDLE.
- All AXI outputs registered; VALIDs never depend combinationally on READYs; AWADDR/WDATA/WSTRB/ARADDR stable from VALID rise until handshake.
- Requests while req_ready=0 are ignored; requester holds request until accepted.
- Simultaneous mem_read and mem_write in IDLE: write only; read is not queued.
- Non-OKAY response (SLVERR/DECERR): transaction still completes normally, resp_err=1.

## Timing
- Reset values: state IDLE, req_ready=1, all VALID/READY outputs 0, M_AXI_* address/data 0, read_data 0, read_valid 0, write_done 0, resp_err 0. Reset mid-transaction drops all VALIDs asynchronously; no completion pulse issued.
- Request accepted at edge N (IDLE, request high) → AWVALID/WVALID or ARVALID high from cycle N+1.
- Zero-wait slave minimum latency: write accepted edge N, AW/W handshake N+1, BREADY high N+2, B handshake N+2, write_done pulse cycle N+3, req_ready=1 cycle N+3. Read identical: read_valid pulse cycle N+3.
- BREADY/RREADY asserted only in WR_RESP/RD_RESP; never before address handshake.
- read_valid/write_done are exactly one cycle wide; req_ready rises in the same cycle as the pulse, so a back-to-back request may be accepted at that edge.
- Arbitrary READY/VALID stalls from the slave extend the corresponding state without bound; no timeout.

## Test plan
- Write 0xDEADBEEF, byte_en 4'hF, addr 0x100, slave AWREADY=WREADY=1, BVALID next cycle BRESP=0 → single AW/W handshake with exact values, write_done pulse at N+3, resp_err=0.
- Write with WREADY delayed 3 cycles after AWREADY → AWVALID drops after its handshake, WVALID held with stable WDATA until WREADY, BREADY only after both; write_done once.
- Read addr 0x200, slave ARREADY after 2 cycles, RDATA 0x12345678 RRESP=2'b10 → read_data=0x12345678, read_valid pulse, resp_err=1.
- mem_read and mem_write both high in IDLE → only AW/W issued, no ARVALID; mem_read held after write_done → read issued next.
- Back-to-back: new write request held high at the write_done cycle → accepted that edge, AWVALID high next cycle.
- rst asserted while ARVALID=1 and ARREADY=0 → ARVALID=0 immediately, req_ready=1, no read_valid pulse after release.
